// File: rtl/ssd_scan_ctrl_pkg.sv
// ssd_scan_ctrl_pkg: shared widths and constants for the seven-segment scan slice
package ssd_scan_ctrl_pkg;
  localparam int SSD_NUM_DIGITS = 8;
  localparam int SSD_NIBBLE_W = 4;
  localparam logic [SSD_NIBBLE_W-1:0] SSD_BLANK_NIBBLE = '0;
  typedef logic [SSD_NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// ssd_scan_ctrl_if: user-side digit inputs and driver/anode-side scan outputs
interface ssd_scan_ctrl_if import ssd_scan_ctrl_pkg::*; #(
  parameter int NUM_DIGITS = SSD_NUM_DIGITS
);
  logic [SSD_NIBBLE_W*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0] dp;
  logic [NUM_DIGITS-1:0] en;
  nibble_t nibble;
  logic dp_out;
  logic [NUM_DIGITS-1:0] an;
  logic frame_tick;
  modport master (output data, dp, en, input nibble, dp_out, an, frame_tick);
  modport slave (input data, dp, en, output nibble, dp_out, an, frame_tick);
endinterface

// File: rtl/ssd_refresh_prescaler.sv
// ssd_refresh_prescaler: mod-DIV slot counter with terminal-count flag
module ssd_refresh_prescaler #(
  parameter int DIV = 100000,
  localparam int CW = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
  output logic [CW-1:0] cnt_o,
  output logic tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == CW'(DIV - 1);
  assign cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: scans NUM_DIGITS shadowed nibbles onto one decoder with per-slot anode blanking
module ssd_scan_ctrl import ssd_scan_ctrl_pkg::*; #(
  parameter int NUM_DIGITS = SSD_NUM_DIGITS,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input logic clk,
  input logic rst,
  ssd_scan_ctrl_if.slave bus
);
  logic [CW-1:0] cnt;
  logic tc, wrap, load;
  logic [IW-1:0] idx_q, idx_d;
  logic load_pend_q;
  logic [SSD_NIBBLE_W*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0] dp_q, en_q;
  nibble_t nibble_q, nibble_d;
  logic dp_out_q, dp_out_d, ft_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  ssd_refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk(clk),
    .rst(rst),
    .cnt_o(cnt),
    .tc_o(tc)
  );
  assign wrap = tc && idx_q == IW'(NUM_DIGITS - 1);
  assign load = wrap || load_pend_q;
  always_comb begin
    idx_d = tc ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    nibble_d = data_q[{idx_q, 2'b00} +: SSD_NIBBLE_W];
    dp_out_d = dp_q[idx_q];
    an_d = (en_q[idx_q] && cnt >= CW'(BLANK_CYCLES)) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end
  // shadows are captured only at frame boundaries so a frame never mixes old and new inputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      load_pend_q <= 1'b1;
      data_q <= '0;
      dp_q <= '0;
      en_q <= '0;
      nibble_q <= SSD_BLANK_NIBBLE;
      dp_out_q <= 1'b0;
      an_q <= '1;
      ft_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      load_pend_q <= 1'b0;
      if (load) begin
        data_q <= bus.data;
        dp_q <= bus.dp;
        en_q <= bus.en;
      end
      nibble_q <= nibble_d;
      dp_out_q <= dp_out_d;
      an_q <= an_d;
      ft_q <= wrap;
    end
  assign bus.nibble = nibble_q;
  assign bus.dp_out = dp_out_q;
  assign bus.an = an_q;
  assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed scan checks with REFRESH_DIV=4, BLANK_CYCLES=1, 8 digits
module tb_ssd_scan_ctrl;
  logic clk, rst;
  int vectors = 0;
  int miscompares = 0;
  logic prev_ft = 1'b0;
  ssd_scan_ctrl_if #(.NUM_DIGITS(8)) bus ();
  ssd_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("an_one_cold", 32'($countones(~bus.an) <= 1), 32'd1);
    if (prev_ft) chk("frame_tick_width", 32'(bus.frame_tick), 32'd0);
    prev_ft <= bus.frame_tick;
  end
  // one full frame: slot k shows nibble k of d, one blank cycle then three anode-low cycles
  task automatic run_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e,
                           input int chg, input logic [31:0] nd, input logic [7:0] np,
                           input logic [7:0] ne);
    logic [7:0] exp_an;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        exp_an = (j == 0 || !e[k]) ? 8'hFF : ~(8'd1 << k);
        chk($sformatf("nibble s%0d c%0d", k, j), 32'(bus.nibble), 32'(d[4*k +: 4]));
        chk($sformatf("dp_out s%0d c%0d", k, j), 32'(bus.dp_out), 32'(p[k]));
        chk($sformatf("an s%0d c%0d", k, j), 32'(bus.an), 32'(exp_an));
        chk($sformatf("frame_tick s%0d c%0d", k, j), 32'(bus.frame_tick), 32'(k == 7 && j == 3));
        if (k == chg && j == 0) begin
          bus.data = nd;
          bus.dp = np;
          bus.en = ne;
        end
      end
  endtask
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.data = 32'h76543210;
    bus.dp = 8'h00;
    bus.en = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset an", 32'(bus.an), 32'hFF);
    chk("reset nibble", 32'(bus.nibble), 32'h0);
    chk("reset dp_out", 32'(bus.dp_out), 32'h0);
    chk("reset frame_tick", 32'(bus.frame_tick), 32'h0);
    rst = 1'b0;
    run_frame(32'h76543210, 8'h00, 8'hFF, 7, 32'h76543210, 8'hA5, 8'hFF);
    run_frame(32'h76543210, 8'hA5, 8'hFF, 7, 32'h76543210, 8'h00, 8'h03);
    run_frame(32'h76543210, 8'h00, 8'h03, 7, 32'h76543210, 8'h00, 8'h00);
    run_frame(32'h76543210, 8'h00, 8'h00, 7, 32'h76543210, 8'h00, 8'hFF);
    run_frame(32'h76543210, 8'h00, 8'hFF, 3, 32'hFEDCBA98, 8'h00, 8'hFF);
    run_frame(32'hFEDCBA98, 8'h00, 8'hFF, 7, 32'h76543210, 8'h00, 8'hFF);
    repeat (22) @(negedge clk);
    chk("pre-reset an slot5", 32'(bus.an), 32'hDF);
    chk("pre-reset nibble slot5", 32'(bus.nibble), 32'h5);
    rst = 1'b1;
    #1;
    chk("async reset an", 32'(bus.an), 32'hFF);
    chk("async reset nibble", 32'(bus.nibble), 32'h0);
    chk("async reset dp_out", 32'(bus.dp_out), 32'h0);
    chk("async reset frame_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(32'h76543210, 8'h00, 8'hFF, 7, 32'h76543210, 8'h00, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
